// File: rtl/fifo_ctrl_8x12_pkg.sv
// Shared definitions for the 8x12 FIFO controller: state encoding, depth and
// default almost-full/almost-empty thresholds.
package fifo_ctrl_8x12_pkg;

    typedef enum logic [3:0] {
        ST_RESET  = 4'd0,
        ST_INIT   = 4'd1,
        ST_IDLE   = 4'd2,
        ST_ACTIVE = 4'd3,
        ST_ERROR  = 4'd4
    } state_t;

    localparam int         FIFO_DEPTH = 8;
    localparam logic [3:0] AFULL_DEF  = 4'd6;
    localparam logic [3:0] AEMPTY_DEF = 4'd2;

    // RAM accesses may only be issued from these two states.
    function automatic logic is_access_state(input state_t s);
        return (s == ST_IDLE) || (s == ST_ACTIVE);
    endfunction

endpackage

// File: rtl/fifo_ctrl_8x12_ptr.sv
// Wrapping FIFO pointer: address bits plus one wrap bit, advanced on an
// accepted access.
module fifo_ptr #(
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    output logic [PTR_W-1:0] o_ptr
);

    logic [PTR_W-1:0] r_ptr;

    // Pointer register, wraps naturally at 2**PTR_W.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            r_ptr <= r_ptr;
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_ctrl_8x12.sv
// Sequencing controller that turns an 8x12 dual-port RAM into a synchronous
// FIFO: pointers, occupancy, flags, sticky errors and the operating FSM.
module fifo_ctrl_8x12
    import fifo_ctrl_8x12_pkg::*;
#(
    parameter int DATA_W     = 12,
    parameter int ADDR_W     = 3,
    parameter int AFULL_RST  = 6,
    parameter int AEMPTY_RST = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic [3:0]        afull_thr,
    input  logic [3:0]        aempty_thr,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [3:0]        fifo_count,
    output logic              overflow_err,
    output logic              underflow_err,
    output logic [3:0]        state,
    output logic [DATA_W-1:0] data_a,
    output logic [ADDR_W-1:0] addr_wa,
    output logic [ADDR_W-1:0] addr_ra,
    output logic              we_a,
    output logic              re_a,
    input  logic [DATA_W-1:0] q_a
);

    localparam int PTR_W = ADDR_W + 1;
    localparam int DEPTH = 2 ** ADDR_W;

    state_t            r_state;
    logic [PTR_W-1:0]  r_count;
    logic [3:0]        r_afull_thr;
    logic [3:0]        r_aempty_thr;
    logic              r_full;
    logic              r_empty;
    logic              r_afull;
    logic              r_aempty;
    logic              r_overflow;
    logic              r_underflow;
    logic              r_pop_valid;
    logic [DATA_W-1:0] r_pop_data;

    logic [PTR_W-1:0]  w_wr_ptr;
    logic [PTR_W-1:0]  w_rd_ptr;
    logic              w_legal;
    logic              w_overflow;
    logic              w_underflow;
    logic              w_push_acc;
    logic              w_pop_acc;
    logic [PTR_W-1:0]  w_count_nxt;
    logic [3:0]        w_afull_thr_nxt;
    logic [3:0]        w_aempty_thr_nxt;

    fifo_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_push_acc),
        .o_ptr (w_wr_ptr)
    );

    fifo_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_pop_acc),
        .o_ptr (w_rd_ptr)
    );

    // Underflow drops a simultaneous push too: there is no empty-FIFO bypass.
    assign w_legal     = is_access_state(r_state);
    assign w_underflow = w_legal & pop & r_empty;
    assign w_overflow  = w_legal & push & r_full & ~pop;
    assign w_pop_acc   = w_legal & pop & ~r_empty;
    assign w_push_acc  = w_legal & push & ~w_underflow & ~w_overflow;

    // Next occupancy from next pointers; thresholds track the inputs only in INIT.
    always_comb begin
        w_count_nxt      = (w_wr_ptr + {{(PTR_W-1){1'b0}}, w_push_acc})
                         - (w_rd_ptr + {{(PTR_W-1){1'b0}}, w_pop_acc});
        w_afull_thr_nxt  = r_afull_thr;
        w_aempty_thr_nxt = r_aempty_thr;
        if (r_state == ST_INIT) begin
            w_afull_thr_nxt  = afull_thr;
            w_aempty_thr_nxt = aempty_thr;
        end else begin
            w_afull_thr_nxt  = r_afull_thr;
            w_aempty_thr_nxt = r_aempty_thr;
        end
    end

    // Operating FSM together with the registered occupancy, flags and read port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_RESET;
            r_count      <= '0;
            r_afull_thr  <= 4'(AFULL_RST);
            r_aempty_thr <= 4'(AEMPTY_RST);
            r_full       <= 1'b0;
            r_empty      <= 1'b1;
            r_afull      <= 1'b0;
            r_aempty     <= 1'b1;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
            r_pop_valid  <= 1'b0;
            r_pop_data   <= '0;
        end else begin
            case (r_state)
                ST_RESET:  r_state <= ST_INIT;
                ST_INIT:   r_state <= init ? ST_INIT : ST_IDLE;
                ST_IDLE: begin
                    if (w_overflow || w_underflow) begin
                        r_state <= ST_ERROR;
                    end else if (init) begin
                        r_state <= ST_INIT;
                    end else if ((r_count != '0) || w_push_acc) begin
                        r_state <= ST_ACTIVE;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ACTIVE: begin
                    if (w_overflow || w_underflow) begin
                        r_state <= ST_ERROR;
                    end else if ((w_count_nxt == '0) && !push) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_ACTIVE;
                    end
                end
                ST_ERROR:  r_state <= ST_ERROR;
                default:   r_state <= ST_ERROR;
            endcase

            r_count      <= w_count_nxt;
            r_afull_thr  <= w_afull_thr_nxt;
            r_aempty_thr <= w_aempty_thr_nxt;
            r_full       <= (32'(w_count_nxt) == DEPTH);
            r_empty      <= (w_count_nxt == '0);
            r_afull      <= (32'(w_count_nxt) >= 32'(w_afull_thr_nxt));
            r_aempty     <= (32'(w_count_nxt) <= 32'(w_aempty_thr_nxt));
            r_overflow   <= r_overflow | w_overflow;
            r_underflow  <= r_underflow | w_underflow;
            r_pop_valid  <= w_pop_acc;
            r_pop_data   <= w_pop_acc ? q_a : r_pop_data;
        end
    end

    assign pop_data      = r_pop_data;
    assign pop_valid     = r_pop_valid;
    assign full          = r_full;
    assign empty         = r_empty;
    assign almost_full   = r_afull;
    assign almost_empty  = r_aempty;
    assign fifo_count    = 4'(r_count);
    assign overflow_err  = r_overflow;
    assign underflow_err = r_underflow;
    assign state         = r_state;
    assign data_a        = push_data;
    assign addr_wa       = w_wr_ptr[ADDR_W-1:0];
    assign addr_ra       = w_rd_ptr[ADDR_W-1:0];
    assign we_a          = w_push_acc;
    assign re_a          = w_pop_acc;

endmodule

// File: tb/tb_fifo_ctrl_8x12.sv
// Scoreboard bench for fifo_ctrl_8x12 with a behavioural RAM and a queue-based
// reference FIFO; read data is checked by an independent monitor process.
module tb_fifo_ctrl_8x12;

    logic        clk = 1'b0;
    logic        reset, init, push, pop;
    logic [3:0]  afull_thr, aempty_thr;
    logic [11:0] push_data, pop_data, data_a, q_a;
    logic        pop_valid, full, empty, almost_full, almost_empty;
    logic [3:0]  fifo_count, state;
    logic        overflow_err, underflow_err;
    logic [2:0]  addr_wa, addr_ra;
    logic        we_a, re_a;

    fifo_ctrl_8x12 dut (
        .clk(clk), .reset(reset), .init(init), .afull_thr(afull_thr),
        .aempty_thr(aempty_thr), .push(push), .push_data(push_data), .pop(pop),
        .pop_data(pop_data), .pop_valid(pop_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .fifo_count(fifo_count), .overflow_err(overflow_err),
        .underflow_err(underflow_err), .state(state), .data_a(data_a),
        .addr_wa(addr_wa), .addr_ra(addr_ra), .we_a(we_a), .re_a(re_a), .q_a(q_a)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: asynchronous read, so a same-address write is read-before-write.
    logic [11:0] mem [0:7];
    assign q_a = mem[addr_ra];
    always @(posedge clk) begin
        if (we_a && (state == 4'd2 || state == 4'd3)) mem[addr_wa] <= data_a;
    end

    // Reference model state.
    logic [11:0] m_q[$];
    logic [11:0] exp_q[$];
    int          wr_n, rd_n, m_afull, m_aempty;
    bit          m_err, m_ovf, m_unf, m_op, m_last_racc;
    logic [11:0] m_last_pd;
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Monitor: every presented read word must match the oldest expected word.
    always @(negedge clk) begin
        if (pop_valid === 1'b1) begin
            if (exp_q.size() == 0) chk("spurious_pop_valid", 32'(pop_valid), 32'd0);
            else chk("pop_data", 32'(pop_data), 32'(exp_q.pop_front()));
        end
    end

    task automatic check_regs();
        int cnt;
        cnt = m_q.size();
        chk("count", 32'(fifo_count), 32'(cnt));
        chk("full", 32'(full), 32'(cnt == 8));
        chk("empty", 32'(empty), 32'(cnt == 0));
        chk("almost_full", 32'(almost_full), 32'(cnt >= m_afull));
        chk("almost_empty", 32'(almost_empty), 32'(cnt <= m_aempty));
        chk("overflow_err", 32'(overflow_err), 32'(m_ovf));
        chk("underflow_err", 32'(underflow_err), 32'(m_unf));
        chk("state", 32'(state), m_err ? 32'd4 : (cnt != 0 ? 32'd3 : 32'd2));
        chk("pop_valid", 32'(pop_valid), 32'(m_last_racc));
        chk("pop_data_hold", 32'(pop_data), 32'(m_last_pd));
    endtask

    // One bus cycle: drive at negedge, check RAM drive, update model at posedge.
    task automatic step(input bit ph, input logic [11:0] pd, input bit pp);
        bit legal, unf, ovf, pacc, racc;
        push = ph; push_data = pd; pop = pp;
        legal = m_op && !m_err;
        unf   = legal && pp && (m_q.size() == 0);
        ovf   = legal && ph && !pp && (m_q.size() == 8);
        pacc  = legal && ph && !unf && !ovf;
        racc  = legal && pp && !unf;
        #1;
        chk("we_a", 32'(we_a), 32'(pacc));
        chk("re_a", 32'(re_a), 32'(racc));
        chk("addr_wa", 32'(addr_wa), 32'(wr_n % 8));
        chk("addr_ra", 32'(addr_ra), 32'(rd_n % 8));
        chk("data_a", 32'(data_a), 32'(pd));
        @(posedge clk);
        m_last_racc = racc;
        if (racc) begin
            m_last_pd = m_q.pop_front();
            exp_q.push_back(m_last_pd);
            rd_n++;
        end
        if (pacc) begin
            m_q.push_back(pd);
            wr_n++;
        end
        if (unf) m_unf = 1'b1;
        if (ovf) m_ovf = 1'b1;
        m_err = m_err | unf | ovf;
        #1;
        check_regs();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; init = 1'b1; push = 1'b0; pop = 1'b0;
        afull_thr = 4'd6; aempty_thr = 4'd2;
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_aempty", 32'(almost_empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_afull", 32'(almost_full), 32'd0);
        chk("rst_pop_valid", 32'(pop_valid), 32'd0);
        chk("rst_pop_data", 32'(pop_data), 32'd0);
        chk("rst_errors", 32'({overflow_err, underflow_err}), 32'd0);
        chk("rst_we_re", 32'({we_a, re_a}), 32'd0);
        chk("rst_addr", 32'({addr_wa, addr_ra}), 32'd0);
        m_q.delete();
        wr_n = 0; rd_n = 0; m_afull = 6; m_aempty = 2;
        m_err = 0; m_ovf = 0; m_unf = 0; m_op = 0;
        m_last_racc = 0; m_last_pd = 12'd0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("state_after_reset", 32'(state), 32'd1);
        @(negedge clk);
    endtask

    task automatic do_init(input logic [3:0] a, input logic [3:0] e);
        init = 1'b1; afull_thr = a; aempty_thr = e;
        @(posedge clk); #1;
        chk("state_init", 32'(state), 32'd1);
        @(negedge clk);
        init = 1'b0;
        @(posedge clk);
        m_afull = int'(a); m_aempty = int'(e); m_op = 1;
        #1;
        check_regs();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 12'd0;
        reset = 1'b1; init = 1'b1; push = 1'b0; pop = 1'b0; push_data = 12'd0;
        afull_thr = 4'd6; aempty_thr = 4'd2;
        @(negedge clk);
        do_reset();
        do_init(4'd6, 4'd2);
        for (int i = 0; i < 3; i++) step(1'b1, 12'($urandom), 1'b0);
        do_reset();
        do_init(4'd6, 4'd2);
        for (int i = 1; i <= 8; i++) step(1'b1, 12'(i), 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 12'd0, 1'b1);
        for (int i = 1; i <= 8; i++) step(1'b1, 12'(i), 1'b0);
        step(1'b1, 12'hABC, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 12'd0, 1'b1);
        step(1'b0, 12'd0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 12'(16 + i), 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 12'h7E7, 1'b0);
        step(1'b0, 12'd0, 1'b0);
        do_reset();
        do_init(4'd6, 4'd2);
        step(1'b1, 12'h5A5, 1'b1);
        step(1'b1, 12'h5A6, 1'b0);
        step(1'b0, 12'd0, 1'b0);

        for (int r = 0; r < 10; r++) begin
            do_reset();
            do_init(4'($urandom_range(0, 9)), 4'($urandom_range(0, 8)));
            for (int s = 0; s < 150; s++) begin
                bit ph, pp;
                afull_thr  = 4'($urandom);
                aempty_thr = 4'($urandom);
                ph = ($urandom_range(0, 99) < 55);
                pp = ($urandom_range(0, 99) < 45);
                if (pp && m_q.size() == 0 && $urandom_range(0, 99) > 2) pp = 1'b0;
                if (ph && !pp && m_q.size() == 8 && $urandom_range(0, 99) > 3) ph = 1'b0;
                step(ph, 12'($urandom), pp);
            end
            step(1'b0, 12'd0, 1'b0);
        end

        step(1'b0, 12'd0, 1'b0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
